snake_body_tracker: RTL and testbench

- Upstream stage of the head collision detector in the 8x8 snake game.
- Holds the ordered snake segment list and, on each movement tick, computes the next head coordinate from the player direction.
- Presents that coordinate to the detector and samples its combinational collide result.
- Then advances or grows the snake, or enters game over.
- Drives the eight row bitmaps consumed by the detector and the LED matrix driver.

---
 rtl/snake_body_tracker.sv | 122 ++++++++++++
 tb/tb_snake_body_tracker.sv | 127 ++++++++++++
 2 files changed

// File: rtl/snake_body_tracker.sv
// Snake segment list and movement FSM for the 8x8 snake game: computes the next head,
// consults the external collision detector, then advances, grows or ends the game.
module snake_body_tracker #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned INIT_X  = 3,
    parameter int unsigned INIT_Y  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic [1:0] dir,
    input  logic       grow,
    input  logic       collide,
    output logic [2:0] coordinate_x,
    output logic [2:0] coordinate_y,
    output logic [7:0] row1,
    output logic [7:0] row2,
    output logic [7:0] row3,
    output logic [7:0] row4,
    output logic [7:0] row5,
    output logic [7:0] row6,
    output logic [7:0] row7,
    output logic [7:0] row8,
    output logic [4:0] length,
    output logic       ready,
    output logic       game_over
);

    typedef enum logic [1:0] {StIdle, StCheck, StMove, StDead} state_e;

    localparam logic [4:0] MaxLen = 5'(MAX_LEN);

    state_e     state_q, state_d;
    logic [2:0] seg_x_q [MAX_LEN];
    logic [2:0] seg_y_q [MAX_LEN];
    logic [4:0] length_q;
    logic [1:0] heading_q;
    logic       grow_q;
    logic [2:0] cand_x_q, cand_y_q;
    logic [1:0] heading_eff;
    logic [2:0] next_x, next_y;
    logic [7:0] rows [8];

    // A request for the exact opposite heading would fold the head into the neck; keep heading.
    always_comb begin
        heading_eff = (dir == (heading_q ^ 2'b10)) ? heading_q : dir;
        next_x      = seg_x_q[0];
        next_y      = seg_y_q[0];
        unique case (heading_eff)
            2'b00:   next_y = seg_y_q[0] - 3'd1;
            2'b01:   next_x = seg_x_q[0] + 3'd1;
            2'b10:   next_y = seg_y_q[0] + 3'd1;
            default: next_x = seg_x_q[0] - 3'd1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (step) state_d = StCheck;
            StCheck: state_d = collide ? StDead : StMove;
            StMove:  state_d = StIdle;
            default: state_d = StDead;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            length_q  <= 5'd3;
            heading_q <= 2'b01;
            grow_q    <= 1'b0;
            cand_x_q  <= 3'(INIT_X);
            cand_y_q  <= 3'(INIT_Y);
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                seg_x_q[i] <= 3'(int'(INIT_X) - i);
                seg_y_q[i] <= 3'(INIT_Y);
            end
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && step) begin
                heading_q <= heading_eff;
                cand_x_q  <= next_x;
                cand_y_q  <= next_y;
                grow_q    <= grow;
            end
            if (state_q == StMove) begin
                for (int i = 1; i < int'(MAX_LEN); i++) begin
                    seg_x_q[i] <= seg_x_q[i-1];
                    seg_y_q[i] <= seg_y_q[i-1];
                end
                seg_x_q[0] <= cand_x_q;
                seg_y_q[0] <= cand_y_q;
                // Shifting always copies the old tail one slot down, so growth is just length+1.
                if (grow_q && length_q < MaxLen) length_q <= length_q + 5'd1;
                grow_q <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 8; r++) rows[r] = 8'h00;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (5'(i) < length_q) rows[seg_y_q[i]][3'd7 - seg_x_q[i]] = 1'b1;
        end
    end

    assign row1         = rows[0];
    assign row2         = rows[1];
    assign row3         = rows[2];
    assign row4         = rows[3];
    assign row5         = rows[4];
    assign row6         = rows[5];
    assign row7         = rows[6];
    assign row8         = rows[7];
    assign coordinate_x = cand_x_q;
    assign coordinate_y = cand_y_q;
    assign length       = length_q;
    assign ready        = (state_q == StIdle);
    assign game_over    = (state_q == StDead);

endmodule

// File: tb/tb_snake_body_tracker.sv
// Directed bench for snake_body_tracker: a default-size instance plus a MAX_LEN=4 instance
// sharing the same stimulus.
module tb_snake_body_tracker;

    logic       clk = 1'b0;
    logic       rst, step, grow, collide;
    logic [1:0] dir;
    logic [2:0] cx, cy, cx4, cy4;
    logic [7:0] r1, r2, r3, r4, r5, r6, r7, r8;
    logic [7:0] q1, q2, q3, q4, q5, q6, q7, q8;
    logic [4:0] len, len4;
    logic       rdy, rdy4, over, over4;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] body_exp;

    always #5 clk = ~clk;

    snake_body_tracker dut (
        .clk(clk), .rst(rst), .step(step), .dir(dir), .grow(grow), .collide(collide),
        .coordinate_x(cx), .coordinate_y(cy),
        .row1(r1), .row2(r2), .row3(r3), .row4(r4), .row5(r5), .row6(r6), .row7(r7), .row8(r8),
        .length(len), .ready(rdy), .game_over(over)
    );

    snake_body_tracker #(.MAX_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .step(step), .dir(dir), .grow(grow), .collide(collide),
        .coordinate_x(cx4), .coordinate_y(cy4),
        .row1(q1), .row2(q2), .row3(q3), .row4(q4), .row5(q5), .row6(q6), .row7(q7), .row8(q8),
        .length(len4), .ready(rdy4), .game_over(over4)
    );

    wire [63:0] rows_all  = {r1, r2, r3, r4, r5, r6, r7, r8};
    wire [63:0] rows_all4 = {q1, q2, q3, q4, q5, q6, q7, q8};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1; step = 1'b0; grow = 1'b0; collide = 1'b0; dir = 2'b01;
        @(posedge clk); #1 rst = 1'b0;
        body_exp = 64'h0000_0070_0000_0000;
    endtask

    // One movement tick; checks the CHECK-cycle candidate, that rows hold until MOVE completes,
    // and the post-move state three cycles after step.
    task automatic do_step(input string tag, input logic [1:0] d, input logic g, input logic c,
                           input logic [2:0] ex, input logic [2:0] ey, input logic [63:0] rows_after);
        @(posedge clk); #1 step = 1'b1; dir = d; grow = g;
        @(posedge clk); #1 step = 1'b0; grow = 1'b0; collide = c;
        check_eq({tag, " cand_x"}, 64'(cx), 64'(ex));
        check_eq({tag, " cand_y"}, 64'(cy), 64'(ey));
        check_eq({tag, " busy"}, 64'(rdy), 64'd0);
        check_eq({tag, " rows_hold"}, rows_all, body_exp);
        @(posedge clk); #1 collide = 1'b0;
        check_eq({tag, " dead"}, 64'(over), 64'(c));
        @(posedge clk); #1;
        check_eq({tag, " rows"}, rows_all, rows_after);
        check_eq({tag, " ready"}, 64'(rdy), 64'(!c));
        body_exp = rows_after;
    endtask

    initial begin
        rst = 1'b0; step = 1'b0; grow = 1'b0; collide = 1'b0; dir = 2'b01;

        do_reset();
        check_eq("rst rows", rows_all, 64'h0000_0070_0000_0000);
        check_eq("rst len", 64'(len), 64'd3);
        check_eq("rst ready", 64'(rdy), 64'd1);
        check_eq("rst over", 64'(over), 64'd0);
        check_eq("rst cx", 64'(cx), 64'd3);
        check_eq("rst cy", 64'(cy), 64'd3);

        do_step("right1", 2'b01, 1'b0, 1'b0, 3'd4, 3'd3, 64'h0000_0038_0000_0000);
        do_step("reverse", 2'b11, 1'b0, 1'b0, 3'd5, 3'd3, 64'h0000_001C_0000_0000);
        do_step("right3", 2'b01, 1'b0, 1'b0, 3'd6, 3'd3, 64'h0000_000E_0000_0000);
        do_step("right4", 2'b01, 1'b0, 1'b0, 3'd7, 3'd3, 64'h0000_0007_0000_0000);
        do_step("wrap", 2'b01, 1'b0, 1'b0, 3'd0, 3'd3, 64'h0000_0083_0000_0000);
        check_eq("wrap len", 64'(len), 64'd3);

        // Grow, turn, then run into the tail.
        do_reset();
        do_step("grow_up", 2'b00, 1'b1, 1'b0, 3'd3, 3'd2, 64'h0000_1070_0000_0000);
        check_eq("grow len", 64'(len), 64'd4);
        do_step("left", 2'b11, 1'b0, 1'b0, 3'd2, 3'd2, 64'h0000_3030_0000_0000);
        do_step("tail_hit", 2'b10, 1'b0, 1'b1, 3'd2, 3'd3, 64'h0000_3030_0000_0000);
        check_eq("dead over", 64'(over), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1 step = 1'b1; dir = 2'b01;
        end
        @(posedge clk); #1 step = 1'b0;
        check_eq("dead frozen", rows_all, 64'h0000_3030_0000_0000);
        check_eq("dead still", 64'(over), 64'd1);
        check_eq("dead len", 64'(len), 64'd4);

        // Reset mid-CHECK: no body update, heading restored to right.
        do_reset();
        @(posedge clk); #1 step = 1'b1; dir = 2'b00;
        @(posedge clk); #1 step = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_eq("midrst rows", rows_all, 64'h0000_0070_0000_0000);
        check_eq("midrst ready", 64'(rdy), 64'd1);
        check_eq("midrst cy", 64'(cy), 64'd3);
        check_eq("midrst len", 64'(len), 64'd3);
        body_exp = 64'h0000_0070_0000_0000;
        do_step("midrst head", 2'b11, 1'b0, 1'b0, 3'd4, 3'd3, 64'h0000_0038_0000_0000);

        // Saturation: default instance grows to 6, MAX_LEN=4 instance stops at 4.
        do_reset();
        do_step("sat1", 2'b01, 1'b1, 1'b0, 3'd4, 3'd3, 64'h0000_0078_0000_0000);
        do_step("sat2", 2'b01, 1'b1, 1'b0, 3'd5, 3'd3, 64'h0000_007C_0000_0000);
        do_step("sat3", 2'b01, 1'b1, 1'b0, 3'd6, 3'd3, 64'h0000_007E_0000_0000);
        check_eq("sat len16", 64'(len), 64'd6);
        check_eq("sat len4", 64'(len4), 64'd4);
        check_eq("sat rows4", rows_all4, 64'h0000_001E_0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
